// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the boot-time system-ID check sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sysid_check_pkg;

    // Sequencer states: two read/wait pairs, one compare cycle, two terminal states.
    typedef enum logic [2:0] {
        RD_ID = 3'd0,
        WT_ID = 3'd1,
        RD_TS = 3'd2,
        WT_TS = 3'd3,
        CMP   = 3'd4,
        PASS  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    // Word addresses inside the sysid control_slave.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Counter widths: read-latency down-counter and retry counter.
    localparam int LAT_W   = 3;
    localparam int RETRY_W = 3;

    // True in the states that present a read strobe to the slave.
    function automatic logic is_rd_state(input state_t s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/sysid_rd_timer.sv
// Loadable down-counter with a zero flag; stops at zero. Used for read-latency and stall timeout.
// Latency: load/decrement take effect on the next clock edge; zero is a registered-count decode.
// Backpressure: none; load has priority over decrement.
module sysid_rd_timer #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: load wins, otherwise decrement and saturate at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sequencer: reads sysid words 0/1, compares, retries, reports sticky pass/fail.
// Latency: zero-wait slave, READ_LATENCY=0 -> done 5 cycles after reset release (2 cycles per read + compare).
// Backpressure: holds av_read/av_address while av_waitrequest=1; optional SYSID_CHECK_TIMEOUT_EN aborts long stalls.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd27,
    parameter logic [31:0] EXPECTED_TS    = 32'd1718188374,
    parameter int          READ_LATENCY   = 0,
    parameter int          MAX_RETRIES    = 2,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                av_address,
    output logic                av_read,
    input  logic                av_waitrequest,
    input  logic [31:0]         av_readdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                id_mismatch,
    output logic                ts_mismatch,
    output logic                timeout,
    output logic [31:0]         read_id,
    output logic [31:0]         read_ts,
    output logic [RETRY_W-1:0]  retry_cnt
);

    // Reject parameter values the counters cannot represent.
    if (READ_LATENCY < 0 || READ_LATENCY > 7 || MAX_RETRIES < 0 || MAX_RETRIES > 7 ||
        TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("sysid_check_ctrl: parameter out of range");
    end

    state_t state;
    logic   accept;
    logic   lat_zero;
    logic   tmo_hit;

    // Strobe is a state decode so the first read issues in the cycle right after reset release;
    // reset gating keeps it low while reset is held.
    assign av_read    = is_rd_state(state) && !reset;
    assign av_address = ((state == RD_TS) || (state == WT_TS)) ? ADDR_TS : ADDR_ID;
    assign accept     = is_rd_state(state) && !av_waitrequest;

    // Read-latency wait: loaded on acceptance, counts down through the WT_* state.
    sysid_rd_timer #(
        .W       (LAT_W),
        .RST_VAL ('0)
    ) u_lat_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .load_val (LAT_W'(READ_LATENCY)),
        .dec      ((state == WT_ID) || (state == WT_TS)),
        .zero     (lat_zero)
    );

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic stall;
    logic tmo_zero;

    assign stall = is_rd_state(state) && av_waitrequest;

    // Preloaded with TIMEOUT_CYCLES-1 whenever not stalling, so reaching zero on a stalled
    // cycle means TIMEOUT_CYCLES consecutive stalled strobe cycles have elapsed.
    sysid_rd_timer #(
        .W       (TMO_W),
        .RST_VAL (TMO_W'(TIMEOUT_CYCLES - 1))
    ) u_tmo_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (!stall),
        .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
        .dec      (stall),
        .zero     (tmo_zero)
    );

    assign tmo_hit = stall && tmo_zero;
`else
    assign tmo_hit = 1'b0;
`endif

    // Sequencer with registered status outputs and captured words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RD_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            read_id     <= '0;
            read_ts     <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                RD_ID, RD_TS: begin
                    if (tmo_hit) begin
                        state   <= FAIL;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else if (accept) begin
                        state <= (state == RD_ID) ? WT_ID : WT_TS;
                    end
                end
                WT_ID: begin
                    if (lat_zero) begin
                        read_id <= av_readdata;
                        state   <= RD_TS;
                    end
                end
                WT_TS: begin
                    if (lat_zero) begin
                        read_ts <= av_readdata;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    id_mismatch <= (read_id != EXPECTED_ID);
                    ts_mismatch <= (read_ts != EXPECTED_TS);
                    if ((read_id == EXPECTED_ID) && (read_ts == EXPECTED_TS)) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        state     <= RD_ID;
                    end else begin
                        state <= FAIL;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end
                end
                PASS, FAIL: begin
                    if (start) begin
                        state       <= RD_ID;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                        retry_cnt   <= '0;
                    end
                end
                default: begin
                    state <= RD_ID;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Self-checking bench for sysid_check_ctrl: table of slave-data vectors plus directed corner sequences.
// Latency: n/a (testbench).
// Backpressure: drives av_waitrequest directly to exercise stalls.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd27;
    localparam logic [31:0] EXP_TS = 32'd1718188374;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- DUT 0: default parameters ----------------
    logic        rst0, start0, wait0, addr0, rd0;
    logic [31:0] rdata0, id_val0, ts_val0, rid0, rts0;
    logic        busy0, done0, pass0, idmm0, tsmm0, tmo0;
    logic [2:0]  retry0;

    always_comb rdata0 = addr0 ? ts_val0 : id_val0;

    sysid_check_ctrl u_dut0 (
        .clock(clock), .reset(rst0), .start(start0),
        .av_address(addr0), .av_read(rd0), .av_waitrequest(wait0), .av_readdata(rdata0),
        .busy(busy0), .done(done0), .pass(pass0), .id_mismatch(idmm0), .ts_mismatch(tsmm0),
        .timeout(tmo0), .read_id(rid0), .read_ts(rts0), .retry_cnt(retry0)
    );

    // ---------------- DUT 2: READ_LATENCY=2 ----------------
    logic        rst2, start2, wait2, addr2, rd2;
    logic [31:0] rdata2, rid2, rts2;
    logic        busy2, done2, pass2, idmm2, tsmm2, tmo2;
    logic [2:0]  retry2;

    always_comb rdata2 = addr2 ? EXP_TS : EXP_ID;

    sysid_check_ctrl #(.READ_LATENCY(2)) u_dut2 (
        .clock(clock), .reset(rst2), .start(start2),
        .av_address(addr2), .av_read(rd2), .av_waitrequest(wait2), .av_readdata(rdata2),
        .busy(busy2), .done(done2), .pass(pass2), .id_mismatch(idmm2), .ts_mismatch(tsmm2),
        .timeout(tmo2), .read_id(rid2), .read_ts(rts2), .retry_cnt(retry2)
    );

`ifdef SYSID_CHECK_TIMEOUT_EN
    // ---------------- DUT T: timeout build, slave stuck ----------------
    logic        rstt, startt, waitt, addrt, rdt;
    logic [31:0] ridt, rtst;
    logic        busyt, donet, passt, idmmt, tsmmt, tmot;
    logic [2:0]  retryt;

    sysid_check_ctrl #(.TIMEOUT_CYCLES(8)) u_dutt (
        .clock(clock), .reset(rstt), .start(startt),
        .av_address(addrt), .av_read(rdt), .av_waitrequest(waitt), .av_readdata(EXP_ID),
        .busy(busyt), .done(donet), .pass(passt), .id_mismatch(idmmt), .ts_mismatch(tsmmt),
        .timeout(tmot), .read_id(ridt), .read_ts(rtst), .retry_cnt(retryt)
    );
`endif

    // Advance DUT0 until done, counting edges and cycles with av_read high (bounded).
    task automatic run0(output int cycles, output int rdc);
        cycles = 0;
        rdc    = 0;
        while (done0 !== 1'b1 && cycles < 100) begin
            if (rd0 === 1'b1) rdc++;
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    typedef struct {
        logic [31:0] id_val;
        logic [31:0] ts_val;
        int          exp_cycles;
        int          exp_rd;
        logic        exp_pass;
        logic        exp_idmm;
        logic        exp_tsmm;
        logic [2:0]  exp_retry;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        int rdc;

        // Vector table: slave words -> expected outcome (3 passes of 5 cycles on any mismatch).
        vecs[0] = '{EXP_ID,            EXP_TS,            5,  2, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{32'd28,            EXP_TS,            15, 6, 1'b0, 1'b1, 1'b0, 3'd2};
        vecs[2] = '{EXP_ID,            32'd0,             15, 6, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[3] = '{32'd0,             32'd0,             15, 6, 1'b0, 1'b1, 1'b1, 3'd2};
        vecs[4] = '{EXP_ID,            32'd1718188375,    15, 6, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[5] = '{32'h8000_001B,     EXP_TS,            15, 6, 1'b0, 1'b1, 1'b0, 3'd2};

        rst0 = 1'b1; start0 = 1'b0; wait0 = 1'b0; id_val0 = EXP_ID; ts_val0 = EXP_TS;
        rst2 = 1'b1; start2 = 1'b0; wait2 = 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
        rstt = 1'b1; startt = 1'b0; waitt = 1'b1;
`endif
        repeat (2) @(posedge clock);
        #1;

        // Reset state.
        check("rst_busy",   busy0,  1);
        check("rst_done",   done0,  0);
        check("rst_pass",   pass0,  0);
        check("rst_av_read", rd0,   0);
        check("rst_av_addr", addr0, 0);
        check("rst_idmm",   idmm0,  0);
        check("rst_tsmm",   tsmm0,  0);
        check("rst_timeout", tmo0,  0);
        check("rst_read_id", rid0,  0);
        check("rst_read_ts", rts0,  0);
        check("rst_retry",  retry0, 0);

        // Table-driven runs on DUT0.
        for (int i = 0; i < 6; i++) begin
            rst0    = 1'b1;
            id_val0 = vecs[i].id_val;
            ts_val0 = vecs[i].ts_val;
            @(negedge clock);
            rst0 = 1'b0;
            #1;
            run0(cyc, rdc);
            check($sformatf("v%0d_cycles", i),  cyc,     vecs[i].exp_cycles);
            check($sformatf("v%0d_rd_cyc", i),  rdc,     vecs[i].exp_rd);
            check($sformatf("v%0d_done", i),    done0,   1);
            check($sformatf("v%0d_busy", i),    busy0,   0);
            check($sformatf("v%0d_pass", i),    pass0,   vecs[i].exp_pass);
            check($sformatf("v%0d_idmm", i),    idmm0,   vecs[i].exp_idmm);
            check($sformatf("v%0d_tsmm", i),    tsmm0,   vecs[i].exp_tsmm);
            check($sformatf("v%0d_retry", i),   retry0,  vecs[i].exp_retry);
            check($sformatf("v%0d_read_id", i), rid0,    vecs[i].id_val);
            check($sformatf("v%0d_read_ts", i), rts0,    vecs[i].ts_val);
        end

        // Reset asserted in WT_TS: outputs return to reset values at once, then auto-restart.
        rst0 = 1'b1; id_val0 = EXP_ID; ts_val0 = EXP_TS;
        @(negedge clock);
        rst0 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("wtts_read_id", rid0, EXP_ID);
        check("wtts_addr",    addr0, 1);
        rst0 = 1'b1;
        #1;
        check("mid_rst_busy",    busy0, 1);
        check("mid_rst_done",    done0, 0);
        check("mid_rst_read_id", rid0,  0);
        check("mid_rst_av_read", rd0,   0);
        check("mid_rst_addr",    addr0, 0);
        @(negedge clock);
        rst0 = 1'b0;
        #1;
        run0(cyc, rdc);
        check("restart_cycles", cyc,   5);
        check("restart_pass",   pass0, 1);

        // start in PASS with the slave now returning TS=0; a second start while busy is ignored.
        ts_val0 = 32'd0;
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        check("start_busy", busy0, 1);
        check("start_done", done0, 0);
        check("start_pass", pass0, 0);
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        run0(cyc, rdc);
        check("rerun_cycles", cyc,    14);
        check("rerun_pass",   pass0,  0);
        check("rerun_tsmm",   tsmm0,  1);
        check("rerun_idmm",   idmm0,  0);
        check("rerun_retry",  retry0, 2);

        // start and reset together in FAIL: reset wins (strobe gated, captures cleared).
        @(negedge clock);
        rst0   = 1'b1;
        start0 = 1'b1;
        @(posedge clock);
        #1;
        check("rst_start_av_read", rd0,    0);
        check("rst_start_read_id", rid0,   0);
        check("rst_start_retry",   retry0, 0);
        check("rst_start_busy",    busy0,  1);
        rst0   = 1'b0;
        start0 = 1'b0;

        // DUT2: 4-cycle stall on the ID read, READ_LATENCY=2.
        @(negedge clock);
        rst2 = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_av_read", i), rd2,   1);
            check($sformatf("stall%0d_addr", i),    addr2, 0);
            @(posedge clock);
            #1;
        end
        wait2 = 1'b0;
        @(posedge clock);
        #1;
        check("accept_av_read", rd2, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("lat2_read_id_%0d", k), rid2, (k == 3) ? EXP_ID : 32'd0);
        end
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("lat2_cycles",  cyc,   5);
        check("lat2_pass",    pass2, 1);
        check("lat2_read_ts", rts2,  EXP_TS);

`ifdef SYSID_CHECK_TIMEOUT_EN
        // Stuck waitrequest with TIMEOUT_CYCLES=8.
        @(negedge clock);
        rstt = 1'b0;
        #1;
        cyc = 0;
        rdc = 0;
        while (donet !== 1'b1 && cyc < 100) begin
            if (rdt === 1'b1) rdc++;
            @(posedge clock);
            #1;
            cyc++;
        end
        check("tmo_rd_cycles", rdc,   8);
        check("tmo_av_read",   rdt,   0);
        check("tmo_timeout",   tmot,  1);
        check("tmo_done",      donet, 1);
        check("tmo_pass",      passt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
